// File: rtl/seq_divmod_pkg.sv
// seq_divmod_pkg: shared types and constants for the iterative unsigned
// divider (seq_divmod) and its single-step datapath (divmod_step).
package seq_divmod_pkg;

  // FSM encoding, also exported on the state_dbg port of seq_divmod.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand / quotient / remainder width.
  localparam int DATAW_DEFAULT = 64;

  // Width of the iteration counter. It must hold the value DATAW.
  function automatic int cnt_width(input int dataw);
    return $clog2(dataw + 1);
  endfunction

endpackage

// File: rtl/divmod_step.sv
// divmod_step: one combinational restoring shift-subtract step.
// It shifts {rem, quot} left by one and tries to subtract the divisor.
// If the result is non-negative, the remainder takes the difference and a
// 1 enters the quotient LSB. Otherwise the shifted remainder is kept and a
// 0 enters the quotient LSB.
module divmod_step
  import seq_divmod_pkg::*;
#(
  parameter int DATAW = DATAW_DEFAULT
) (
  input  logic [DATAW:0]   rem_in,
  input  logic [DATAW-1:0] quot_in,
  input  logic [DATAW-1:0] divisor,
  output logic [DATAW:0]   rem_out,
  output logic [DATAW-1:0] quot_out
);

  logic [DATAW:0] rem_shift;
  logic [DATAW:0] trial;
  logic           unused_msb;

  // The partial remainder never exceeds the divisor, so its top bit is
  // always 0 on entry. It is shifted out here.
  assign unused_msb = rem_in[DATAW];

  assign rem_shift = {rem_in[DATAW-1:0], quot_in[DATAW-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  // Restore or keep: the MSB of trial is the sign of the subtraction.
  always_comb begin
    rem_out  = rem_shift;
    quot_out = {quot_in[DATAW-2:0], 1'b0};
    if (!trial[DATAW]) begin
      rem_out     = trial;
      quot_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divmod.sv
// seq_divmod: multi-cycle unsigned divider.
// It computes the quotient and the remainder in DATAW cycles, one restoring
// step per cycle, behind a start/ready/done handshake.
// Optional feature macro SEQ_DIVMOD_DBZ_EN adds the dbz (divide-by-zero)
// flag output.
//
// Handshake: a request transfers on a rising clock edge where start=1 and
// ready=1. ready is high in IDLE and DONE. start is ignored while busy=1.
// done pulses high for one cycle when quot/rem are final. Those values
// stay valid until the next accepted start.
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int DATAW = DATAW_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [DATAW-1:0] dividend,
  input  logic [DATAW-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [DATAW-1:0] quot,
  output logic [DATAW-1:0] rem,
`ifdef SEQ_DIVMOD_DBZ_EN
  output logic             dbz,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = cnt_width(DATAW);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [DATAW:0]   rem_q;
  logic [DATAW-1:0] quot_q;
  logic [DATAW-1:0] div_q;
  logic [DATAW:0]   rem_nx;
  logic [DATAW-1:0] quot_nx;
  logic             accept;

  // A start is taken in any state that advertises ready.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  divmod_step #(.DATAW(DATAW)) u_step (
    .rem_in  (rem_q),
    .quot_in (quot_q),
    .divisor (div_q),
    .rem_out (rem_nx),
    .quot_out(quot_nx)
  );

  // State register. Reset returns to IDLE and overrides start.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RUN lasts exactly DATAW cycles. DONE can chain
  // directly into a new RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state register. All of these are derived from
  // flops only, so there is no input-to-output path.
  always_comb begin
    ready     = (state_q != RUN);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    state_dbg = state_q;
  end

  // Datapath: load operands on accept and iterate while in RUN.
  // Reset discards the operation in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      rem_q  <= '0;
      quot_q <= dividend;
      div_q  <= divisor;
      cnt_q  <= CW'(DATAW);
    end else if (state_q == RUN) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q[DATAW-1:0];

`ifdef SEQ_DIVMOD_DBZ_EN
  logic dbz_q;

  // The divide-by-zero flag is reloaded on every accepted start.
  always_ff @(posedge Clk) begin
    if (Rst)         dbz_q <= 1'b0;
    else if (accept) dbz_q <= (divisor == '0);
  end

  assign dbz = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divmod.sv
// tb_seq_divmod: self-checking bench for seq_divmod (DATAW=64).
module tb_seq_divmod;

  localparam int DATAW  = 64;
  localparam int W      = 2 * DATAW;
  localparam int BUDGET = 200;

  logic             clk;
  logic             rst;
  logic             start;
  logic [DATAW-1:0] dividend;
  logic [DATAW-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [DATAW-1:0] quot;
  logic [DATAW-1:0] rem;
  logic [1:0]       state_dbg;
`ifdef SEQ_DIVMOD_DBZ_EN
  logic             dbz;
`endif

  int n_checks;
  int n_fail;

  // Expected {quot, rem} pairs, pushed on accept and popped on done.
  logic [W-1:0] exp_q[$];

  seq_divmod #(.DATAW(DATAW)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
`ifdef SEQ_DIVMOD_DBZ_EN
    .dbz      (dbz),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [DATAW-1:0] a,
                                         input logic [DATAW-1:0] b);
    if (b == '0) return {{DATAW{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive a one-cycle start pulse. On return, the bench is at the negedge
  // of cycle 1.
  task automatic drive_op(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Measure the cycle number at which done is seen. The count starts at
  // cycle 1. busy_bad counts RUN cycles with the wrong busy/ready values.
  // lat is -1 if the budget expires.
  task automatic wait_done(output int lat, output int busy_bad);
    busy_bad = 0;
    lat      = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
      @(negedge clk);
    end
  endtask

  // Pop the scoreboard and compare it with the outputs at the done cycle.
  task automatic check_result(input string name);
    logic [W-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: scoreboard empty at done", name);
      return;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({quot, rem} !== exp) begin
      n_fail++;
      $display("FAIL %s_result: quot=%h rem=%h expected quot=%h rem=%h",
               name, quot, rem, exp[W-1:DATAW], exp[DATAW-1:0]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (quot !== '0 || rem !== '0) begin
      n_fail++;
      $display("FAIL reset_data: quot=%h rem=%h expected 0/0", quot, rem);
    end
    n_checks++;
    if ({done, busy, ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ctrl: done/busy/ready=%b expected 001", {done, busy, ready});
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d expected 0", state_dbg);
    end
`ifdef SEQ_DIVMOD_DBZ_EN
    n_checks++;
    if (dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dbz: dbz=%b expected 0", dbz);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, bad;
    drive_op(64'd100, 64'd7);
    wait_done(lat, bad);
    n_checks++;
    if (lat != DATAW + 1) begin
      n_fail++;
      $display("FAIL basic_latency: done at cycle %0d expected %0d", lat, DATAW + 1);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL basic_busy: %0d bad RUN cycles expected 0", bad);
    end
    check_result("basic");
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_done: ready=%b expected 1", ready);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || quot !== 64'd14 || rem !== 64'd2) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b ready=%b quot=%0d rem=%0d expected 0 1 14 2",
               done, ready, quot, rem);
    end
  endtask

  task automatic test_random();
    int lat, bad;
    logic [DATAW-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      b = (i % 2 == 0) ? DATAW'($urandom_range(1, 1000)) : {32'($urandom_range(0, 3)), $urandom};
      if (b == '0) b = 64'd1;
      drive_op(a, b);
      wait_done(lat, bad);
      n_checks++;
      if (lat != DATAW + 1 || bad != 0) begin
        n_fail++;
        $display("FAIL random_timing: lat=%0d bad=%0d expected %0d 0", lat, bad, DATAW + 1);
      end
      check_result("random");
      @(negedge clk);
    end
  endtask

  task automatic test_dbz();
    int lat, bad;
    drive_op(64'h1234, 64'd0);
    wait_done(lat, bad);
    n_checks++;
    if (lat != DATAW + 1) begin
      n_fail++;
      $display("FAIL dbz_latency: done at cycle %0d expected %0d", lat, DATAW + 1);
    end
    check_result("dbz");
`ifdef SEQ_DIVMOD_DBZ_EN
    n_checks++;
    if (dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_flag_set: dbz=%b expected 1", dbz);
    end
`endif
    @(negedge clk);
    drive_op(64'd10, 64'd3);
`ifdef SEQ_DIVMOD_DBZ_EN
    n_checks++;
    if (dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_flag_clear: dbz=%b expected 0", dbz);
    end
`endif
    wait_done(lat, bad);
    check_result("dbz_next");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    start    = 1'b1;
    dividend = '1;
    divisor  = 64'd1;
    exp_q.push_back(model('1, 64'd1));
    @(negedge clk);
    // start stays high. The new operands wait for the DONE cycle.
    dividend = 64'd5;
    divisor  = 64'd10;
    exp_q.push_back(model(64'd5, 64'd10));
    wait_done(lat, bad);
    n_checks++;
    if (lat != DATAW + 1 || bad != 0) begin
      n_fail++;
      $display("FAIL b2b_first_timing: lat=%0d bad=%0d expected %0d 0", lat, bad, DATAW + 1);
    end
    check_result("b2b_first");
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_accept_in_done: busy=%b state=%0d expected 1 1", busy, state_dbg);
    end
    wait_done(lat, bad);
    n_checks++;
    if (lat != DATAW + 1) begin
      n_fail++;
      $display("FAIL b2b_second_latency: done at cycle %0d expected %0d", lat, DATAW + 1);
    end
    check_result("b2b_second");
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat, bad, extra;
    drive_op(64'd100, 64'd7);
    repeat (9) @(negedge clk);
    // Cycle 10 of RUN: this request must have no effect.
    start    = 1'b1;
    dividend = 64'd50;
    divisor  = 64'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bad);
    n_checks++;
    if (lat != DATAW + 1 - 10) begin
      n_fail++;
      $display("FAIL ignored_latency: done at cycle %0d expected %0d", lat, DATAW + 1 - 10);
    end
    check_result("ignored");
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignored_extra_done: %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    start    = 1'b1;
    dividend = 64'd1000;
    divisor  = 64'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (state_dbg !== 2'd0 || quot !== '0 || rem !== '0 || {done, busy, ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_state: state=%0d quot=%h rem=%h dbr=%b expected 0 0 0 001",
               state_dbg, quot, rem, {done, busy, ready});
    end
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: %0d done pulses expected 0", seen);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_dbz();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divmod.md
# seq_divmod

Multi-cycle unsigned divider that computes quotient and remainder of one dividend/divisor pair over DATAW clock cycles using a restoring shift-subtract algorithm. It sits directly upstream of the compare/select/register stage of the datapath circuits. Its quotient feeds the select inputs, and its remainder feeds the zero-compare. It replaces the pair of single-cycle DIV and MOD instances for the same operands with one shared, area-cheap iterative unit behind a start/done handshake.

## Interface
- DATAW, 64: operand, quotient and remainder width in bits; legal range 2..64.
- Clk  input  1  rising-edge clock, sole clock domain.
- Rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only while ready=1.
- dividend  input  DATAW  unsigned dividend; captured on accepted start.
- divisor  input  DATAW  unsigned divisor; captured on accepted start.
- ready  output  1  block can accept start this cycle.
- busy  output  1  iteration in progress.
- done  output  1  one-cycle pulse; quot/rem valid.
- quot  output  DATAW  quotient; held until next accepted start.
- rem  output  DATAW  remainder; held until next accepted start.
- dbz  output  1  divide-by-zero flag; only present with SEQ_DIVMOD_DBZ_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch the dividend into the quotient shift register. Latch the divisor into the divisor register. Clear the partial remainder (DATAW+1 bits). Load the counter with DATAW. Go to RUN.
- RUN: one restoring step per cycle:
  - Shift {rem, quot} left by 1.
  - Trial = rem_shifted − {1'b0, divisor}.
  - If the trial is non-negative (MSB=0), rem ← trial and quot LSB ← 1; otherwise rem is kept and quot LSB ← 0.
  - Counter decrements.
  - When the counter reaches 1 and that step completes, go to DONE.
- DONE: done=1 and ready=1 for exactly one cycle. A start sampled in DONE is accepted exactly as in IDLE and goes to RUN, giving back-to-back operation. Otherwise go to IDLE.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accept cycle.
- Divide by zero needs no special path; the algorithm naturally yields quot = all ones and rem = dividend.
- Arithmetic is unsigned only. The counter is $clog2(DATAW+1) bits. The partial remainder is DATAW+1 bits internally, and rem is the low DATAW bits.
- Reset (any state, including mid-RUN) has these effects:
  - state=IDLE, quot=0, rem=0, done=0, busy=0, ready=1, dbz=0.
  - The operation in flight is discarded, with no done pulse.
  - Rst has priority over start in the same cycle.

## Timing
- Cycle 0: start accepted (IDLE or DONE).
- Cycles 1..DATAW: busy=1, ready=0.
- Cycle DATAW+1: done=1, final quot/rem visible; latency is DATAW+1 cycles from start to done.
- Throughput: one result per DATAW+1 cycles when start is held high continuously.
- quot/rem update every RUN cycle (intermediate values). Consumers sample them only on done or later, while ready=1 and no new start has been accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SEQ_DIVMOD_DBZ_EN defined: adds the dbz output.
  - dbz is set in the accept cycle's next state when divisor==0.
  - It is held through DONE and until the next accepted start, which reloads it.
  - Rst clears it.
  - The quot/rem values and the timing are unchanged.
- Undefined: no dbz port and no flag register; the behaviour is otherwise identical.

## Structure
- Package seq_divmod_pkg holds:
  - the state enumeration (IDLE, RUN, DONE);
  - the default DATAW constant (64);
  - a counter-width helper function.
- Sub-module divmod_step: the combinational single restoring step.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next partial remainder, next quotient.
  - Parameterised by DATAW and instantiated once.
- The top level holds the FSM, counter, operand registers and output registers.

## Test plan
- Reset: assert Rst for 2 cycles -> quot=0, rem=0, done=0, busy=0, ready=1.
- DATAW=64, dividend=100, divisor=7, start one cycle -> done exactly 65 cycles later, with quot=14 and rem=2; busy high for cycles 1..64.
- Divide by zero: dividend=0x1234, divisor=0 -> quot=0xFFFF_FFFF_FFFF_FFFF and rem=0x1234; with SEQ_DIVMOD_DBZ_EN also dbz=1, and dbz=0 after the next start with divisor=3.
- Back-to-back with start held high: 0xFFFF_FFFF_FFFF_FFFF/1 then 5/10 -> first done gives quot=all ones and rem=0; the second start is accepted in the DONE cycle; the second done comes 65 cycles later with quot=0 and rem=5.
- Ignored start: pulse start with different operands at cycle 10 of RUN -> the original result is unaffected and there is no extra done.
- Mid-operation reset: assert Rst at cycle 30 of RUN -> the next cycle is IDLE with all outputs zero; no done pulse ever appears for the aborted operation.
